// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// opcode constants (instr[6:2]) and the decoded opcode-class record.
// No ports; imported by op_class_dec and multicycle_ctrl.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALUI   = 5'b00100;
    localparam logic [4:0] OP_ALU    = 5'b01100;

    // Everything the FSM needs to know about an instruction after DECODE.
    typedef struct packed {
        logic legal;
        logic branch;
        logic load;
        logic store;
        logic regwrite;
    } op_class_t;

endpackage

// File: rtl/op_class_dec.sv
// Combinational opcode classifier.
// Ports:
//   op  - opcode field instr[6:2]
//   cls - legal/branch/load/store/regwrite flags; all zero for an unknown opcode
module op_class_dec
    import multicycle_pkg::*;
(
    input  logic [4:0] op,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_BRANCH: begin
                cls.legal  = 1'b1;
                cls.branch = 1'b1;
            end
            OP_LOAD: begin
                cls.legal    = 1'b1;
                cls.load     = 1'b1;
                cls.regwrite = 1'b1;
            end
            OP_STORE: begin
                cls.legal = 1'b1;
                cls.store = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ALUI, OP_ALU: begin
                cls.legal    = 1'b1;
                cls.regwrite = 1'b1;
            end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH,
// with an absorbing HALT state, plus cycle and retired-instruction counters.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   op, is_halt         - opcode field and halt-word detect from the IR
//   imem_ready          - instruction word returned this cycle
//   dmem_ready          - data access completes this cycle
//   InstrMemEn, IRWr    - fetch request, IR load (IRWr gated by imem_ready)
//   MemEn, MemWr        - data request and write qualifier
//   RegWr, PCWr         - register file write, PC update (one per retirement)
//   state               - current FSM state (debug/observability)
//   done, illegal       - sticky halt / halted-on-unknown-opcode flags
//   cycle_cnt, instret  - non-HALT cycles since reset, retired instructions
//
// Memory handshake: a request (InstrMemEn in FETCH, MemEn in MEM) is held high
// every cycle until the matching ready is sampled high at a clock edge; that
// edge completes the transfer. A ready seen while no request is pending is
// ignored.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  op,
    input  logic        is_halt,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        InstrMemEn,
    output logic        IRWr,
    output logic        MemEn,
    output logic        MemWr,
    output logic        RegWr,
    output logic        PCWr,
    output logic [2:0]  state,
    output logic        done,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    state_t    cur, nxt;
    op_class_t dec_cls, cls_q;
    logic      illegal_q;
    logic      fetch_en, ir_wr, mem_en, mem_wr, reg_wr, pc_wr;

    op_class_dec u_op_class_dec (
        .op  (op),
        .cls (dec_cls)
    );

    // The class is captured in DECODE so later states never depend on op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_FETCH;
            cls_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                cls_q <= dec_cls;
                if (!is_halt && !dec_cls.legal) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt      = cur;
        fetch_en = 1'b0;
        ir_wr    = 1'b0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        reg_wr   = 1'b0;
        pc_wr    = 1'b0;
        case (cur)
            S_FETCH: begin
                fetch_en = 1'b1;
                if (imem_ready) begin
                    ir_wr = 1'b1;
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt || !dec_cls.legal) begin
                    nxt = S_HALT;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q.branch) begin
                    pc_wr = 1'b1;
                    nxt   = S_FETCH;
                end else if (cls_q.load || cls_q.store) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_en = 1'b1;
                mem_wr = cls_q.store;
                if (dmem_ready) begin
                    if (cls_q.store) begin
                        pc_wr = 1'b1;
                        nxt   = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr = 1'b1;
                pc_wr  = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            // Unused encodings park in HALT rather than retire garbage.
            default: nxt = S_HALT;
        endcase
    end

    // Reset masks the strobes combinationally: the state register already
    // reads FETCH during reset, which would otherwise raise InstrMemEn.
    assign InstrMemEn = fetch_en & ~rst;
    assign IRWr       = ir_wr    & ~rst;
    assign MemEn      = mem_en   & ~rst;
    assign MemWr      = mem_wr   & ~rst;
    assign RegWr      = reg_wr   & ~rst;
    assign PCWr       = pc_wr    & ~rst;

    assign state   = cur;
    assign done    = (cur == S_HALT);
    assign illegal = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (cur != S_HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (pc_wr) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state changes on posedge clk.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 op  in  5  opcode field instr[6:2] from instruction register; stable from DECODE to end of instruction.
REQ-004 is_halt  in  1  high when instruction register holds 32'hdead10cc.
REQ-005 imem_ready  in  1  instruction memory has returned the word this cycle.
REQ-006 dmem_ready  in  1  data memory access completes this cycle.
REQ-007 InstrMemEn  out  1  instruction fetch request.
REQ-008 IRWr  out  1  load instruction register.
REQ-009 MemEn  out  1  data memory request.
REQ-010 MemWr  out  1  data memory write qualifier; valid only with MemEn.
REQ-011 RegWr  out  1  register file write strobe.
REQ-012 PCWr  out  1  PC update strobe; exactly one pulse per retired instruction.
REQ-013 state  out  3  current FSM state encoding.
REQ-014 done  out  1  sticky halt indicator.
REQ-015 illegal  out  1  sticky, set when halt is caused by an unknown opcode.
REQ-016 cycle_cnt  out  32  cycles since reset, excluding HALT.
REQ-017 instret  out  32  retired instruction count.

Function
REQ-018 States SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-019 In FETCH: assert InstrMemEn; on imem_ready, pulse IRWr and go to DECODE; otherwise remain in FETCH.
REQ-020 In DECODE: latch the opcode class.
- If is_halt, go to HALT with illegal=0.
- Else if op is not one of 01101, 00101, 11011, 11001, 11000, 00000, 01000, 00100, 01100, go to HALT and set illegal=1.
- Else go to EXEC.
REQ-021 EXEC transitions:
- BRANCH (11000): pulse PCWr, go to FETCH.
- LOAD (00000) or STORE (01000): go to MEM.
- All other legal opcodes: go to WB.
REQ-022 In MEM: assert MemEn, with MemWr=1 for STORE only; hold both until dmem_ready.
- On dmem_ready for STORE: pulse PCWr, go to FETCH.
- On dmem_ready for LOAD: go to WB.
REQ-023 In WB: pulse RegWr and PCWr together for one cycle, then go to FETCH.
REQ-024 HALT SHALL be absorbing until reset.
- done=1.
- All strobes low.
- Counters frozen.
REQ-025 Strobes SHALL be Moore outputs of state plus the latched class, except: IRWr is gated by imem_ready, and PCWr in MEM is gated by dmem_ready.
REQ-026 Latency with ready high in the first cycle:
- BRANCH: 3 cycles.
- ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.
- Each ready-low cycle adds one cycle.
REQ-027 cycle_cnt SHALL increment every non-HALT cycle, wrapping modulo 2^32.
REQ-028 instret SHALL increment on each PCWr, wrapping modulo 2^32.
REQ-029 A ready input asserted while the FSM is not waiting on it SHALL be ignored.
REQ-030 RegWr and MemEn SHALL never be high in the same cycle.
REQ-031 MemWr SHALL never be high without MemEn.

Reset
REQ-032 While rst is high:
- state=FETCH.
- All strobes forced to 0, InstrMemEn included.
- done=0, illegal=0.
- cycle_cnt=0, instret=0.
REQ-033 Reset asserted in any state, including mid-MEM with MemEn high, SHALL take effect immediately, without waiting for a clock.
REQ-034 The first fetch SHALL occur in the first cycle after rst deasserts.

Structure
REQ-035 State encoding, opcode constants and the opcode-class type SHALL reside in the shared package multicycle_pkg.
REQ-036 Opcode classification (legal/branch/load/store/regwrite) SHALL be a combinational sub-module op_class_dec.
REQ-037 The counters SHALL stay inside multicycle_ctrl.

Verification
REQ-038 ADD (op=01100), both readies tied high -> states FETCH, DECODE, EXEC, WB, FETCH; RegWr and PCWr high in cycle 4 only; instret=1.
REQ-039 LOAD, dmem_ready low for 2 MEM cycles -> MemEn high for 3 cycles with MemWr=0; WB follows; total 7 cycles; instret=1.
REQ-040 STORE then BEQ, readies high -> MemWr=1 in exactly one cycle; PCWr pulses at cycles 4 and 7; RegWr never high; instret=2.
REQ-041 is_halt=1 at DECODE after 3 retired instructions -> done=1, illegal=0, instret=3; cycle_cnt frozen for 10 further cycles.
REQ-042 op=11111 -> HALT with illegal=1, no PCWr pulse.
REQ-043 rst pulsed asynchronously mid-MEM -> MemEn drops before the next clock edge; counters=0, state=FETCH.
